// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio path: sample width, silence code,
// PWM stage states, prescaler derivation and the volume/mute scaler.
package audio_pkg;

    localparam int AUDIO_W = 8;
    localparam logic [AUDIO_W-1:0] SILENCE = 8'h80;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } pwm_state_e;

    // Clock cycles per PWM counter tick, never below one.
    function automatic int calc_prescale(input int clk_freq,
                                         input int pwm_freq);
        int p;
        p = clk_freq / (pwm_freq * 256);
        return (p < 1) ? 1 : p;
    endfunction

    // Offset-binary -> two's complement is an MSB flip, so the arithmetic
    // shift happens around the silence code and is flipped back after.
    function automatic logic [AUDIO_W-1:0] scale_sample(
        input logic [AUDIO_W-1:0] smp,
        input logic [1:0]         vol,
        input logic               mute
    );
        logic signed [AUDIO_W-1:0] t;
        t = {~smp[AUDIO_W-1], smp[AUDIO_W-2:0]};
        t = t >>> vol;
        return mute ? SILENCE : {~t[AUDIO_W-1], t[AUDIO_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_pwm_tx_pwm_counter_gen.sv
// PWM carrier: prescaler, 8-bit period counter, period boundary pulse and
// registered compare output. Ports: run_i, duty_i in; pwm_o, boundary_o out.
module pwm_counter_gen
    import audio_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_i,
    input  logic [AUDIO_W-1:0] duty_i,
    output logic               pwm_o,
    output logic               boundary_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q;
    logic [7:0]    cnt_q;
    logic          pwm_q;
    logic          tick;

    assign tick       = (presc_q == PW'(PRESCALE - 1));
    assign boundary_o = run_i && tick && (cnt_q == 8'hFF);
    assign pwm_o      = pwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
        end else if (!run_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end
            pwm_q <= (cnt_q < duty_i);
        end
    end

endmodule

// File: rtl/audio_pwm_tx.sv
// PWM audio output stage: double-buffered duty, volume/mute, amp shutdown,
// starvation and overrun flags. Ports: sample stream in; pwm_out/sd_n/status out.
module audio_pwm_tx
    import audio_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int PWM_FREQ     = 390_625,
    parameter int HOLD_PERIODS = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               mute,
    input  logic [1:0]         volume,
    input  logic [AUDIO_W-1:0] audio_data,
    input  logic               audio_valid,
    input  logic               clear_status,
    output logic               pwm_out,
    output logic               sd_n,
    output logic               sample_taken,
    output logic               underrun,
    output logic               overrun,
    output logic [15:0]        underrun_count
);

    localparam int PRESCALE = calc_prescale(CLK_FREQ, PWM_FREQ);
    localparam int HW       = $clog2(HOLD_PERIODS + 1);

    pwm_state_e         state_q;
    logic [AUDIO_W-1:0] duty_q;
    logic [AUDIO_W-1:0] pending_q;
    logic               pending_full_q;
    logic [HW-1:0]      idle_cnt_q;
    logic [HW-1:0]      idle_cnt_d;
    logic               sd_n_q;
    logic               taken_q;
    logic               underrun_q;
    logic               overrun_q;
    logic [15:0]        urc_q;

    logic run;
    logic boundary;
    logic consume;
    logic capture;
    logic ovr_set;
    logic starve;

    // Gating with enable makes the carrier stop on the same edge the FSM leaves.
    assign run        = enable && (state_q != IDLE);
    assign capture    = run && audio_valid;
    assign consume    = boundary && pending_full_q;
    assign ovr_set    = capture && pending_full_q && !consume;
    assign idle_cnt_d = idle_cnt_q + 1'b1;
    assign starve     = boundary && !pending_full_q && (state_q == RUN)
                        && (idle_cnt_d == HW'(HOLD_PERIODS));

    pwm_counter_gen #(
        .PRESCALE (PRESCALE)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_i      (run),
        .duty_i     (duty_q),
        .pwm_o      (pwm_out),
        .boundary_o (boundary)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            duty_q         <= SILENCE;
            pending_q      <= SILENCE;
            pending_full_q <= 1'b0;
            idle_cnt_q     <= '0;
            sd_n_q         <= 1'b0;
            taken_q        <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
            urc_q          <= '0;
        end else begin
            taken_q <= 1'b0;
            if (!enable) begin
                state_q        <= IDLE;
                sd_n_q         <= 1'b0;
                duty_q         <= SILENCE;
                pending_full_q <= 1'b0;
                idle_cnt_q     <= '0;
            end else begin
                sd_n_q <= 1'b1;
                unique case (state_q)
                    IDLE: begin
                        state_q    <= RUN;
                        duty_q     <= SILENCE;
                        idle_cnt_q <= '0;
                    end
                    RUN, STARVED: begin
                        if (consume) begin
                            state_q    <= RUN;
                            duty_q     <= scale_sample(pending_q, volume, mute);
                            taken_q    <= 1'b1;
                            idle_cnt_q <= '0;
                        end else if (starve) begin
                            state_q <= STARVED;
                            duty_q  <= SILENCE;
                        end else if (boundary && state_q == RUN) begin
                            idle_cnt_q <= idle_cnt_d;
                        end
                        if (capture) begin
                            pending_q <= audio_data;
                        end
                        pending_full_q <= capture || (pending_full_q && !consume);
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // Clear first so a same-cycle set takes precedence.
            if (clear_status) begin
                underrun_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (starve) begin
                underrun_q <= 1'b1;
                if (urc_q != 16'hFFFF) begin
                    urc_q <= urc_q + 16'd1;
                end
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign sd_n           = sd_n_q;
    assign sample_taken   = taken_q;
    assign underrun       = underrun_q;
    assign overrun        = overrun_q;
    assign underrun_count = urc_q;

endmodule

// File: tb/tb_audio_pwm_tx.sv
// Directed bench for audio_pwm_tx: expected duty per sample is queued when
// the sample is driven and compared against measured high time when taken.
module tb_audio_pwm_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mute;
    logic [1:0]  volume;
    logic [7:0]  audio_data;
    logic        audio_valid;
    logic        clear_status;
    logic        pwm_out;
    logic        sd_n;
    logic        sample_taken;
    logic        underrun;
    logic        overrun;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    audio_pwm_tx dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .mute           (mute),
        .volume         (volume),
        .audio_data     (audio_data),
        .audio_valid    (audio_valid),
        .clear_status   (clear_status),
        .pwm_out        (pwm_out),
        .sd_n           (sd_n),
        .sample_taken   (sample_taken),
        .underrun       (underrun),
        .overrun        (overrun),
        .underrun_count (underrun_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] d);
        audio_valid = 1'b1;
        audio_data  = d;
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    task automatic wait_taken(input string tag);
        int n = 0;
        while (sample_taken !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_taken"}, 32'(sample_taken), 32'd1);
    endtask

    // Counts pwm_out high over one full period; pops the expected duty.
    task automatic measure(input string tag);
        int hi = 0;
        logic [31:0] exp;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, "_pulse"}, 32'(sample_taken), 32'd0);
            if (pwm_out === 1'b1) hi++;
        end
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
        chk(tag, 32'(hi), exp);
    endtask

    initial begin
        int tk;
        reset_n      = 1'b0;
        enable       = 1'b0;
        mute         = 1'b0;
        volume       = 2'd0;
        audio_data   = 8'h00;
        audio_valid  = 1'b0;
        clear_status = 1'b0;

        @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_sdn", 32'(sd_n), 32'd0);
        chk("rst_flags", 32'({sample_taken, underrun, overrun}), 32'd0);
        chk("rst_urc", 32'(underrun_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_sdn", 32'(sd_n), 32'd0);

        // Sample offered in IDLE must be ignored.
        strobe(8'h00);

        enable = 1'b1;
        @(negedge clk);
        chk("run_sdn", 32'(sd_n), 32'd1);
        sb.push_back(32'd128);
        measure("mid_duty");
        repeat (4096 - 257) @(negedge clk);
        chk("pre_starve", 32'(underrun), 32'd0);
        @(negedge clk);
        chk("starve_flag", 32'(underrun), 32'd1);
        chk("starve_cnt", 32'(underrun_count), 32'd1);

        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("clr_under", 32'(underrun), 32'd0);
        chk("clr_cnt", 32'(underrun_count), 32'd1);

        sb.push_back(32'd32);
        strobe(8'h20);
        wait_taken("starved_exit");
        measure("starved_exit");

        sb.push_back(32'd192);
        strobe(8'hC0);
        wait_taken("v0");
        measure("v0");

        volume = 2'd2;
        sb.push_back(32'd144);
        strobe(8'hC0);
        wait_taken("v2");
        measure("v2");

        volume = 2'd1;
        sb.push_back(32'd64);
        strobe(8'h00);
        wait_taken("v1_zero");
        measure("v1_zero");

        volume = 2'd0;
        mute = 1'b1;
        sb.push_back(32'd128);
        strobe(8'hC0);
        wait_taken("mute");
        mute = 1'b0;
        measure("mute");
        chk("no_ovr", 32'(overrun), 32'd0);

        sb.push_back(32'd240);
        strobe(8'h10);
        strobe(8'hF0);
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_taken("ovr");
        measure("ovr");

        // Measure ends on the first cycle of a period (cnt = 0).
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("clr_ovr", 32'(overrun), 32'd0);
        chk("clr_ovr_under", 32'(underrun), 32'd0);

        sb.push_back(32'd80);
        sb.push_back(32'd112);
        strobe(8'h50);
        repeat (253) @(negedge clk);
        strobe(8'h70);
        chk("coin_taken", 32'(sample_taken), 32'd1);
        chk("coin_no_ovr", 32'(overrun), 32'd0);
        wait_taken("coin1");
        measure("coin1");
        wait_taken("coin2");
        measure("coin2");

        strobe(8'h90);
        chk("pre_drop_pwm", 32'(pwm_out), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_pwm", 32'(pwm_out), 32'd0);
        chk("drop_sdn", 32'(sd_n), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_sdn", 32'(sd_n), 32'd1);
        sb.push_back(32'd128);
        measure("reen_duty");
        tk = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sample_taken === 1'b1) tk++;
        end
        chk("discarded", 32'(tk), 32'd0);
        chk("keep_cnt", 32'(underrun_count), 32'd1);

        #2;
        reset_n = 1'b0;
        #1;
        chk("async_pwm", 32'(pwm_out), 32'd0);
        chk("async_sdn", 32'(sd_n), 32'd0);
        chk("async_cnt", 32'(underrun_count), 32'd0);
        chk("async_flags", 32'({sample_taken, underrun, overrun}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
